inst_fetch_unit: RTL

Instruction fetch stage sitting directly upstream of the instruction decoder. Holds the PC and issues word-aligned fetch requests to instruction memory. Buffers returned 32-bit instructions in a small in-order queue and presents them, with their PC, to the decoder over a valid/ready handshake. Accepts redirects (branch/jump) from execute, flushing queued and in-flight instructions.

---
 rtl/inst_fetch_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: PC generation, credit-limited imem requests, in-order instruction queue to decode.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirect targets raise sticky misalign_err and halt fetch.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          QUEUE_DEPTH     = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   input  logic        if_ready,
   output logic        misalign_err
);

   localparam int QW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CW = $clog2(QUEUE_DEPTH) + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int SW = ((CW > OW) ? CW : OW) + 1;

   logic [31:0]   pc_reg;
   logic [31:0]   q_inst_reg [QUEUE_DEPTH];
   logic [31:0]   q_pc_reg   [QUEUE_DEPTH];
   logic [QW-1:0] q_head_reg, q_tail_reg;
   logic [CW-1:0] q_count_reg;
   logic [31:0]   tag_reg [MAX_OUTSTANDING];
   logic [TW-1:0] tag_wr_reg, tag_rd_reg;
   logic [OW-1:0] outstanding_reg, outstanding_next, drop_cnt_reg;
   logic [SW-1:0] credit_sum;
   logic [31:0]   target;
   logic [31:0]   tag_head;
   logic          fetch_halt;
   logic          accept, q_push, q_pop, q_full;

   function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
      return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
   endfunction

`ifdef FETCH_MISALIGN_CHECK_EN
   logic misalign_reg;

   assign target       = redirect_target;
   assign fetch_halt   = misalign_reg;
   assign misalign_err = misalign_reg;

   always_ff @(posedge clk) begin
      if (rst)
         misalign_reg <= 1'b0;
      else if (redirect_valid && (redirect_target[1:0] != 2'b00))
         misalign_reg <= 1'b1;
   end
`else
   assign target       = redirect_target & 32'hFFFF_FFFC;
   assign fetch_halt   = 1'b0;
   assign misalign_err = 1'b0;
`endif

   // Credits cover both queued entries and in-flight requests so a response always has a slot.
   assign credit_sum       = SW'(q_count_reg) + SW'(outstanding_reg);
   assign imem_req_valid   = !rst && !redirect_valid && !fetch_halt &&
                             (credit_sum < SW'(QUEUE_DEPTH)) &&
                             (outstanding_reg < OW'(MAX_OUTSTANDING));
   assign imem_req_addr    = {pc_reg[31:2], 2'b00};
   assign accept           = imem_req_valid && imem_req_ready;
   assign outstanding_next = outstanding_reg + OW'(accept) - OW'(imem_rsp_valid);

   assign tag_head = tag_reg[tag_rd_reg];
   assign q_full   = (q_count_reg == CW'(QUEUE_DEPTH));
   assign q_push   = imem_rsp_valid && (drop_cnt_reg == '0) && !redirect_valid;
   assign q_pop    = if_valid && if_ready && !redirect_valid;

   assign if_valid = !rst && (q_count_reg != '0);
   assign if_inst  = if_valid ? q_inst_reg[q_head_reg] : 32'h0;
   assign if_pc    = if_valid ? q_pc_reg[q_head_reg]   : 32'h0;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg          <= RESET_PC;
         q_head_reg      <= '0;
         q_tail_reg      <= '0;
         q_count_reg     <= '0;
         tag_wr_reg      <= '0;
         tag_rd_reg      <= '0;
         outstanding_reg <= '0;
         drop_cnt_reg    <= '0;
      end else begin
         if (redirect_valid)
            pc_reg <= target;
         else if (accept)
            pc_reg <= pc_reg + 32'd4;

         if (redirect_valid) begin
            q_head_reg  <= '0;
            q_tail_reg  <= '0;
            q_count_reg <= '0;
         end else begin
            if (q_push)
               q_tail_reg <= q_tail_reg + QW'(1);
            if (q_pop)
               q_head_reg <= q_head_reg + QW'(1);
            q_count_reg <= q_count_reg + CW'(q_push) - CW'(q_pop);
         end

         // Tags of stale requests stay in the FIFO and are retired as their responses drain.
         if (accept)
            tag_wr_reg <= tag_inc(tag_wr_reg);
         if (imem_rsp_valid)
            tag_rd_reg <= tag_inc(tag_rd_reg);
         outstanding_reg <= outstanding_next;

         if (redirect_valid)
            drop_cnt_reg <= outstanding_next;
         else if (imem_rsp_valid && (drop_cnt_reg != '0))
            drop_cnt_reg <= drop_cnt_reg - OW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         tag_reg[tag_wr_reg] <= pc_reg;
      if (q_push) begin
         q_inst_reg[q_tail_reg] <= imem_rsp_data;
         q_pc_reg[q_tail_reg]   <= tag_head;
      end
   end

   assert property (@(posedge clk) disable iff (rst) !(q_push && q_full && !q_pop));

endmodule
